// File: rtl/io_bus_master_if.sv
// Command, response and device-side signals of the 8-bit IO bus initiator.
// master: the io_bus_master itself; slave: the command source plus the IO devices.
interface io_bus_master_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 16
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [ADDRESS_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0]    cmd_wdata;

    logic                     rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_err;

    logic [ADDRESS_WIDTH-1:0] io_addr;
    logic [DATA_WIDTH-1:0]    io_wdata;
    logic [DATA_WIDTH-1:0]    io_rdata;
    logic                     rd_n;
    logic                     wr_n;
    logic                     io_ready;

    logic                     int_n;
    logic                     irq;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  io_rdata, io_ready, int_n,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output io_addr, io_wdata, rd_n, wr_n, irq
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output io_rdata, io_ready, int_n,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  io_addr, io_wdata, rd_n, wr_n, irq
    );
endinterface

// File: rtl/io_bus_master.sv
// IO bus initiator: one command at a time through T1-T2-T3-[TW]-T4, plus int_n synchroniser.
// Define IO_MASTER_TIMEOUT_EN to abort stalled cycles after TIMEOUT_CYCLES not-ready cycles.
module io_bus_master #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned ADDRESS_WIDTH   = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 16,
    parameter int unsigned IRQ_SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst_n,
    io_bus_master_if.master bus
);

    if (IRQ_SYNC_STAGES < 2) begin : gen_bad_sync
        $error("IRQ_SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : gen_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StT3,
        StTw,
        StT4
    } state_e;

    state_e                   state_q, state_d;
    logic                     op_write_q, op_write_d;
    logic [ADDRESS_WIDTH-1:0] io_addr_q, io_addr_d;
    logic [DATA_WIDTH-1:0]    io_wdata_q, io_wdata_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic                     rd_n_q, rd_n_d;
    logic                     wr_n_q, wr_n_d;
    logic [IRQ_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                     strobe_phase;

`ifdef IO_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CntW-1:0] tmo_cnt_inc;
    logic            rsp_err_q, rsp_err_d;

    assign tmo_cnt_inc = tmo_cnt_q + CntW'(1);
`endif

    // Next-state, command capture and response data.
    always_comb begin
        state_d     = state_q;
        op_write_d  = op_write_q;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef IO_MASTER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        rsp_err_d   = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    op_write_d = bus.cmd_write;
                    io_addr_d  = bus.cmd_addr;
                    io_wdata_d = bus.cmd_wdata;
                    state_d    = StT1;
                end
            end
            StT1: state_d = StT2;
            StT2: begin
                state_d = StT3;
`ifdef IO_MASTER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            StT3, StTw: begin
                if (bus.io_ready) begin
                    if (!op_write_q) begin
                        rsp_rdata_d = bus.io_rdata;
                    end
                    state_d = StT4;
                end else begin
`ifdef IO_MASTER_TIMEOUT_EN
                    // A ready seen on the same edge takes priority over the abort.
                    if (tmo_cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '1;
                        state_d     = StT4;
                    end else begin
                        tmo_cnt_d = tmo_cnt_inc;
                        state_d   = StTw;
                    end
`else
                    state_d = StTw;
`endif
                end
            end
            StT4:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Strobes and the response pulse are registered from the next state so the
    // device-facing lines come straight off flops.
    always_comb begin
        strobe_phase = (state_d == StT2) || (state_d == StT3) || (state_d == StTw);
        rd_n_d       = !strobe_phase;
        wr_n_d       = !(strobe_phase && op_write_d);
        rsp_valid_d  = (state_d == StT4);
        sync_d       = {sync_q[IRQ_SYNC_STAGES-2:0], ~bus.int_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_write_q  <= 1'b0;
            io_addr_q   <= '0;
            io_wdata_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_write_q  <= op_write_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            sync_q      <= sync_d;
        end
    end

`ifdef IO_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.io_addr   = io_addr_q;
    assign bus.io_wdata  = io_wdata_q;
    assign bus.rd_n      = rd_n_q;
    assign bus.wr_n      = wr_n_q;
    assign bus.irq       = sync_q[IRQ_SYNC_STAGES-1];

`ifndef SYNTHESIS
    // Devices qualify writes with both strobes low, so wr_n alone must never be low.
    assert property (@(posedge clk) disable iff (!rst_n) !wr_n_q |-> !rd_n_q);
    assert property (@(posedge clk) disable iff (!rst_n) rsp_valid_q |-> (state_q == StT4));
`endif

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: driver pushes expected responses, a monitor checks them.
module tb_io_bus_master;
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 16;
    localparam int unsigned TMO  = 16;
    localparam int unsigned SYNC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_bus_master_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    io_bus_master #(
        .DATA_WIDTH     (DW),
        .ADDRESS_WIDTH  (AW),
        .TIMEOUT_CYCLES (TMO),
        .IRQ_SYNC_STAGES(SYNC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int         cyc;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rsp_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor / scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.rsp_valid) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: rsp_valid at cycle %0d with nothing expected", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents a command and returns at the negedge of T1. acc is the cycle in
    // which the accept edge closes, so T1 is acc+1 and T4 is acc+4 without waits.
    task automatic send(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                        input int lat, input logic [7:0] exp_rd, input logic exp_err,
                        input bit push, input bit hold, output int acc, output int waits);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        waits = 0;
        while (!bus.cmd_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: cmd_ready got 0 expected 1 within 50 cycles");
        end
        acc = cyc;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.cmd_valid = 1'b0;
        if (push) exp_q.push_back('{acc + lat, exp_rd, exp_err});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int acc1, acc2, w1, w2, seen0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.io_rdata  = '0;
        bus.io_ready  = 1'b1;
        bus.int_n     = 1'b1;

        step(2);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_io_addr", 32'(bus.io_addr), 0);
        chk("rst_io_wdata", 32'(bus.io_wdata), 0);
        chk("rst_rd_n", 32'(bus.rd_n), 1);
        chk("rst_wr_n", 32'(bus.wr_n), 1);
        chk("rst_irq", 32'(bus.irq), 0);
        rst_n = 1'b1;
        step(1);

        // Zero-wait write; rsp_rdata still holds its reset value.
        send(1'b1, 16'hFF04, 8'hA5, 4, 8'h00, 1'b0, 1'b1, 1'b0, acc1, w1);
        chk("wr_t1_rd_n", 32'(bus.rd_n), 1);
        chk("wr_t1_wr_n", 32'(bus.wr_n), 1);
        chk("wr_t1_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("wr_io_addr", 32'(bus.io_addr), 32'h0000_FF04);
        chk("wr_io_wdata", 32'(bus.io_wdata), 32'h0000_00A5);
        step(1);
        chk("wr_t2_rd_n", 32'(bus.rd_n), 0);
        chk("wr_t2_wr_n", 32'(bus.wr_n), 0);
        step(1);
        chk("wr_t3_rd_n", 32'(bus.rd_n), 0);
        chk("wr_t3_wr_n", 32'(bus.wr_n), 0);
        step(1);
        chk("wr_t4_rd_n", 32'(bus.rd_n), 1);
        chk("wr_t4_wr_n", 32'(bus.wr_n), 1);
        step(1);
        chk("wr_idle_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("wr_addr_hold", 32'(bus.io_addr), 32'h0000_FF04);

        // Read with three wait states; data only valid on the exit edge.
        bus.io_ready = 1'b0;
        bus.io_rdata = 8'h11;
        send(1'b0, 16'h1C10, 8'h00, 7, 8'h3C, 1'b0, 1'b1, 1'b0, acc1, w1);
        step(2);
        chk("rd_t3_rd_n", 32'(bus.rd_n), 0);
        chk("rd_t3_wr_n", 32'(bus.wr_n), 1);
        step(2);
        chk("rd_tw_rd_n", 32'(bus.rd_n), 0);
        chk("rd_tw_wr_n", 32'(bus.wr_n), 1);
        step(1);
        bus.io_ready = 1'b1;
        bus.io_rdata = 8'h3C;
        step(2);

        // Back-to-back with cmd_valid held; the write keeps the last read data.
        bus.io_rdata = 8'h5A;
        send(1'b1, 16'h0300, 8'h77, 4, 8'h3C, 1'b0, 1'b1, 1'b1, acc1, w1);
        send(1'b0, 16'h0301, 8'h00, 4, 8'h5A, 1'b0, 1'b1, 1'b0, acc2, w2);
        chk("b2b_accept_gap", 32'(acc2 - acc1), 5);
        chk("b2b_ready_low_cycles", 32'(w2), 4);
        step(4);
        chk("b2b_io_addr", 32'(bus.io_addr), 32'h0000_0301);

        // Device never ready.
        bus.io_ready = 1'b0;
        bus.io_rdata = 8'h77;
`ifdef IO_MASTER_TIMEOUT_EN
        send(1'b0, 16'h0042, 8'h00, 3 + TMO, 8'hFF, 1'b1, 1'b1, 1'b0, acc1, w1);
        step(20);
        chk("tmo_back_idle", 32'(bus.cmd_ready), 1);
        chk("tmo_rdata_hold", 32'(bus.rsp_rdata), 32'h0000_00FF);
        bus.io_ready = 1'b1;
`else
        send(1'b0, 16'h0042, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0, acc1, w1);
        seen0 = rsp_seen;
        step(40);
        chk("stall_no_rsp", 32'(rsp_seen - seen0), 0);
        chk("stall_rd_n", 32'(bus.rd_n), 0);
        chk("stall_cmd_ready", 32'(bus.cmd_ready), 0);
        bus.io_ready = 1'b1;
        exp_q.push_back('{cyc + 1, 8'h77, 1'b0});
        step(2);
        chk("stall_back_idle", 32'(bus.cmd_ready), 1);
`endif

        // Interrupt synchroniser latency.
        bus.int_n = 1'b0;
        step(1);
        chk("irq_set_1", 32'(bus.irq), 0);
        step(1);
        chk("irq_set_2", 32'(bus.irq), 1);
        bus.int_n = 1'b1;
        step(1);
        chk("irq_clr_1", 32'(bus.irq), 1);
        step(1);
        chk("irq_clr_2", 32'(bus.irq), 0);
        bus.int_n = 1'b0;
        step(2);
        chk("irq_pre_rst", 32'(bus.irq), 1);

        // Asynchronous reset in the middle of T2; that command is dropped.
        send(1'b1, 16'h1234, 8'h99, 0, 8'h00, 1'b0, 1'b0, 1'b0, acc1, w1);
        step(1);
        chk("mid_t2_wr_n", 32'(bus.wr_n), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_n", 32'(bus.rd_n), 1);
        chk("mid_rst_wr_n", 32'(bus.wr_n), 1);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("mid_rst_irq", 32'(bus.irq), 0);
        chk("mid_rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        chk("mid_rst_io_addr", 32'(bus.io_addr), 0);
        bus.int_n = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(1);

        // Recovery after reset.
        send(1'b1, 16'h0010, 8'hC3, 4, 8'h00, 1'b0, 1'b1, 1'b0, acc1, w1);
        step(5);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
